mul_div_unit: RTL

Iterative 32-bit unsigned multiply/divide unit sitting directly downstream of the ALU operand-B select mux, alongside the ALU. It consumes the register-file operand A and the muxed operand B and produces a 32-bit result after a fixed 32-iteration sequence. `busy` stalls the PC and register-file write-back while it runs. One operation is in flight at a time; the result is held until the next accepted start.

---
 rtl/mul_div_unit_pkg.sv | 18 +
 rtl/mul_div_unit_if.sv | 18 +
 rtl/mul_div_unit.sv | 73 +++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the control
// decoder that drives its op/start inputs.
package mul_div_unit_pkg;

   typedef enum logic [1:0] {
      MDU_MUL   = 2'b00,
      MDU_MULHU = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_REMU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_RUN  = 2'b01,
      MDU_DONE = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the operand muxes and the multiply/divide unit.
// The master side issues start/op/operands; the slave side returns busy/done/result.
interface mul_div_unit_if #(parameter int WIDTH = 32);
   import mul_div_unit_pkg::*;

   logic             start;
   mdu_op_e          op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, op, operand_a, operand_b,
                   input  busy, done, result);
   modport slave  (input  start, op, operand_a, operand_b,
                   output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Unsigned MUL/MULHU/DIVU/REMU, one iteration per cycle: result and a one-cycle
// done arrive WIDTH+1 cycles after start; start is ignored while busy.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_div_unit_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mdu_state_e         state;
   mdu_op_e            op_q;
   logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor
   logic [2*WIDTH-1:0] acc;        // {product hi | remainder, multiplier | dividend/quotient}
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   result_q;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   result_nxt;

   always_comb begin
      add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_q};
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
      if (op_q[1]) begin
         if (diff[WIDTH])
            acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
      // MUL/DIVU live in the low half, MULHU/REMU in the high half.
      result_nxt = op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= MDU_IDLE;
         op_q     <= MDU_MUL;
         opnd_q   <= '0;
         acc      <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else if (state == MDU_RUN) begin
         acc <= acc_nxt;
         cnt <= cnt + 1'b1;
         if (cnt == CW'(WIDTH-1)) begin
            result_q <= result_nxt;
            state    <= MDU_DONE;
         end
      end else if (bus.start) begin
         op_q   <= bus.op;
         opnd_q <= bus.op[1] ? bus.operand_b : bus.operand_a;
         acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? bus.operand_a : bus.operand_b)};
         cnt    <= '0;
         state  <= MDU_RUN;
      end else begin
         state <= MDU_IDLE;
      end
   end

   assign bus.busy   = (state == MDU_RUN);
   assign bus.done   = (state == MDU_DONE);
   assign bus.result = result_q;

endmodule
